vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Source end of the VGA timing bus consumed by the draw stages: hcount/vcount,
//   hsync/vsync and hblnk/vblnk.
//   Free-running pixel/line counters produce one fully registered, mutually aligned
//   timing word per pclk. A frame_start strobe marks the first pixel of each frame.
//   Sits at the head of the draw pipeline: background -> ball -> paddles -> VGA pins.
// PARAMETERS
//   H_ACTIVE  800  visible pixels per line
//   H_FP      40   horizontal front porch (pixels)
//   H_SYNC    128  hsync pulse width (pixels)
//   H_BP      88   horizontal back porch (pixels)
//   V_ACTIVE  600  visible lines per frame
//   V_FP      1    vertical front porch (lines)
//   V_SYNC    4    vsync pulse width (lines)
//   V_BP      23   vertical back porch (lines)
//   HS_POL    1    hsync active level (1 = active-high)
//   VS_POL    1    vsync active level (1 = active-high)
// PORTS
//   pclk         in   1   pixel clock (40 MHz for the 800x600@60 defaults)
//   rst_n        in   1   asynchronous, active-low reset
//   en           in   1   count enable; 0 freezes counters and all outputs
//   hcount_out   out  11  pixel index within line, 0..H_TOTAL-1
//   hsync_out    out  1   horizontal sync, level per HS_POL
//   hblnk_out    out  1   1 when hcount_out >= H_ACTIVE
//   vcount_out   out  11  line index within frame, 0..V_TOTAL-1
//   vsync_out    out  1   vertical sync, level per VS_POL
//   vblnk_out    out  1   1 when vcount_out >= V_ACTIVE
//   frame_start  out  1   one-cycle pulse when outputs show (0,0) after a frame wrap
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
//   - Both totals must be <= 2048. Counters are unsigned 11-bit.
//   - Reset, asynchronous on rst_n=0:
//       hcount_out = 0, vcount_out = 0
//       hblnk_out = 0, vblnk_out = 0, frame_start = 0
//       hsync_out = ~HS_POL, vsync_out = ~VS_POL
//   - Release of rst_n is taken synchronously. The first counting edge moves hcount_out 0->1.
//   - Counting, on pclk rising edge with en=1:
//       hcount_out == H_TOTAL-1 -> hcount wraps to 0, otherwise hcount + 1
//       vcount advances only on the hcount wrap
//       vcount_out == V_TOTAL-1 at that wrap -> vcount wraps to 0, otherwise vcount + 1
//   - Alignment: all flags are decoded from the NEXT counter values and registered on the
//     same edge. hblnk/hsync/vblnk/vsync/frame_start therefore always describe the
//     hcount_out/vcount_out pair in the same cycle. Latency from count to flag is 0 cycles.
//   - hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967 at defaults).
//   - vsync active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604 at defaults).
//   - vsync and vblnk change only in the cycle where hcount_out becomes 0.
//   - frame_start = 1 exactly in the cycle after (H_TOTAL-1, V_TOTAL-1) -> (0,0).
//     It is not asserted on the reset-state (0,0).
//   - en = 0: every output register holds, including frame_start. A pulse that is high
//     when en drops stays high until the next enabled edge.
//   - Reset mid-frame: outputs return to reset values immediately, with no frame_start.
// TESTING
//   1 Assert rst_n=0 mid-line -> all outputs reach reset values with no clock edge;
//     hsync_out = vsync_out = 0.
//   2 Release reset, run 1056 edges with en=1 -> hcount 0..1055 then 0, vcount 0->1 on the
//     wrap, hblnk 0 for hcount 0..799 and 1 for 800..1055.
//   3 Within one line -> hsync_out = 1 exactly for hcount 840..967 (128 cycles); hblnk and
//     hsync transitions land in the same cycle as the matching hcount value.
//   4 Run to vcount 600..627 -> vblnk = 1 from (0,600); vsync = 1 from (0,601) through
//     (1055,604); vsync = 0 at (0,605).
//   5 Step from (1055,627) -> (0,0) with frame_start = 1 for exactly one cycle; frame
//     period = 663168 cycles.
//   6 Drop en for 5 cycles at (839,10) -> all outputs frozen; after en=1 the next edge
//     gives (840,10) with hsync = 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// VGA timing bus carried from the timing generator to the draw stages.
// The generator drives it (master); each draw stage samples it (slave).
interface vga_timing_gen_if;
   logic [10:0] hcount_out;
   logic        hsync_out;
   logic        hblnk_out;
   logic [10:0] vcount_out;
   logic        vsync_out;
   logic        vblnk_out;
   logic        frame_start;

   modport master (
      output hcount_out, hsync_out, hblnk_out,
      output vcount_out, vsync_out, vblnk_out, frame_start
   );
   modport slave (
      input hcount_out, hsync_out, hblnk_out,
      input vcount_out, vsync_out, vblnk_out, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running pixel/line counters with sync, blank and frame-start flags.
// Flags are decoded from the next counter values so every output shares one register stage.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             en,
   vga_timing_gen_if.master vga
);

   localparam logic [10:0] H_MAX  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_MAX  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] hcount, vcount, h_nxt, v_nxt;
   logic        hsync, hblnk, vsync, vblnk, fstart;

   always_comb begin
      h_nxt = hcount + 11'd1;
      v_nxt = vcount;
      if (hcount == H_MAX) begin
         h_nxt = '0;
         v_nxt = (vcount == V_MAX) ? 11'd0 : vcount + 11'd1;
      end
   end

   // (0,0) is only re-entered through a frame wrap, so the reset state never pulses.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
         hblnk  <= 1'b0;
         vblnk  <= 1'b0;
         hsync  <= ~HS_POL;
         vsync  <= ~VS_POL;
         fstart <= 1'b0;
      end else if (en) begin
         hcount <= h_nxt;
         vcount <= v_nxt;
         hblnk  <= (h_nxt >= H_ACT);
         vblnk  <= (v_nxt >= V_ACT);
         hsync  <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
         vsync  <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
         fstart <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
      end
   end

   assign vga.hcount_out  = hcount;
   assign vga.vcount_out  = vcount;
   assign vga.hblnk_out   = hblnk;
   assign vga.vblnk_out   = vblnk;
   assign vga.hsync_out   = hsync;
   assign vga.vsync_out   = vsync;
   assign vga.frame_start = fstart;

endmodule
